// File: rtl/vga_fb_pkg.sv
// Shared widths, pixel-entry payload and FSM states for the framebuffer write bridge.
package vga_fb_pkg;

    localparam int unsigned FB_WORDS = 307200;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned COLOR_W  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_entry_t;

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_CLR_PEND = 2'd1,
        ST_CLEAR    = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/vga_fb_write_bridge_if.sv
// Processor store port, clear request and VGA pixel-RAM write port of the bridge.
interface vga_fb_write_bridge_if;
    import vga_fb_pkg::*;

    logic               iWR_EN;
    logic [31:0]        iWR_ADDR;
    logic [31:0]        iWR_DATA;
    logic               iCLR_REQ;
    logic [COLOR_W-1:0] iCLR_COLOR;
    logic               iPIX_READY;
    logic               oPIX_WE;
    logic [ADDR_W-1:0]  oPIX_ADDR;
    logic [COLOR_W-1:0] oPIX_DATA;
    logic               oBUSY;
    logic               oFULL;
    logic [15:0]        oDROP_CNT;

    modport master (
        output iWR_EN, iWR_ADDR, iWR_DATA, iCLR_REQ, iCLR_COLOR, iPIX_READY,
        input  oPIX_WE, oPIX_ADDR, oPIX_DATA, oBUSY, oFULL, oDROP_CNT
    );

    modport slave (
        input  iWR_EN, iWR_ADDR, iWR_DATA, iCLR_REQ, iCLR_COLOR, iPIX_READY,
        output oPIX_WE, oPIX_ADDR, oPIX_DATA, oBUSY, oFULL, oDROP_CNT
    );

endinterface

// File: rtl/fb_sync_fifo.sv
// Single-clock pixel FIFO; head entry is read straight from the storage registers.
module fb_sync_fifo
    import vga_fb_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  pix_entry_t       wdata,
    input  logic             pop,
    output pix_entry_t       rdata,
    output logic [CNT_W-1:0] count
);

    pix_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Payload storage; caller never pushes when full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; caller never pops when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/vga_fb_write_bridge.sv
// Decodes framebuffer stores, queues them, and drains them (or a clear-screen fill) to VGA RAM.
module vga_fb_write_bridge #(
    parameter logic [31:0] FB_BASE  = 32'h0000_1000,
    parameter int unsigned FB_WORDS = vga_fb_pkg::FB_WORDS,
    parameter int unsigned DEPTH    = 16
) (
    input logic                  iCLK,
    input logic                  iRST_n,
    vga_fb_write_bridge_if.slave bus
);
    import vga_fb_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fsm_state_t         state, state_d;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_d;
    logic [COLOR_W-1:0] clr_color, clr_color_d;
    logic [CNT_W-1:0]   count;
    pix_entry_t         head, push_entry, emit_entry;
    logic               hit, push, pop, emit, drop;
    logic               fifo_full, fifo_empty;
    logic               pix_we;
    logic [ADDR_W-1:0]  pix_addr;
    logic [COLOR_W-1:0] pix_data;
    logic [15:0]        drop_cnt;
    logic               unused_data;

    assign unused_data = ^bus.iWR_DATA[31:COLOR_W];

    // Window decode done in 33 bits so a window ending at the top of memory cannot wrap.
    assign hit = bus.iWR_EN && (bus.iWR_ADDR >= FB_BASE)
              && (33'(bus.iWR_ADDR) < (33'(FB_BASE) + 33'(FB_WORDS)));
    assign push_entry = '{addr: ADDR_W'(bus.iWR_ADDR - FB_BASE),
                          color: bus.iWR_DATA[COLOR_W-1:0]};

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    fb_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (iCLK),
        .rst_n (iRST_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // Next-state, FIFO handshake and emitted-pixel selection.
    always_comb begin
        state_d     = state;
        clr_cnt_d   = clr_cnt;
        clr_color_d = clr_color;
        push        = 1'b0;
        pop         = 1'b0;
        emit        = 1'b0;
        emit_entry  = head;
        unique case (state)
            ST_DRAIN: begin
                push = hit && !fifo_full;
                pop  = !fifo_empty && bus.iPIX_READY;
                emit = pop;
                if (bus.iCLR_REQ) begin
                    clr_color_d = bus.iCLR_COLOR;
                    state_d     = ST_CLR_PEND;
                end
            end
            ST_CLR_PEND: begin
                pop  = !fifo_empty && bus.iPIX_READY;
                emit = pop;
                if (fifo_empty) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (bus.iPIX_READY) begin
                    emit       = 1'b1;
                    emit_entry = '{addr: clr_cnt, color: clr_color};
                    if (clr_cnt == ADDR_W'(FB_WORDS - 1)) begin
                        clr_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        clr_cnt_d = ADDR_W'(clr_cnt + 1'b1);
                    end
                end
            end
            default: state_d = ST_DRAIN;
        endcase
    end

    // Any hit that is not queued is a drop (full FIFO or clear in progress).
    assign drop = hit && !push;

    // FSM state, clear counter and latched fill colour.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= ST_DRAIN;
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            state     <= state_d;
            clr_cnt   <= clr_cnt_d;
            clr_color <= clr_color_d;
        end
    end

    // Registered pixel write port and saturating drop counter.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pix_we   <= 1'b0;
            pix_addr <= '0;
            pix_data <= '0;
            drop_cnt <= '0;
        end else begin
            pix_we <= emit;
            if (emit) begin
                pix_addr <= emit_entry.addr;
                pix_data <= emit_entry.color;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= 16'(drop_cnt + 16'd1);
            end
        end
    end

    assign bus.oPIX_WE   = pix_we;
    assign bus.oPIX_ADDR = pix_addr;
    assign bus.oPIX_DATA = pix_data;
    assign bus.oDROP_CNT = drop_cnt;
    assign bus.oFULL     = fifo_full;
    assign bus.oBUSY     = (state != ST_DRAIN) || !fifo_empty;

endmodule
